// File: rtl/bvinv_pkg.sv
// Shared types and helpers for the bit-vector udiv inverse solver.
package bvinv_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StMul  = 3'd1,
        StDivA = 3'd2,
        StDivB = 3'd3,
        StDone = 3'd4
    } bvinv_state_e;

    localparam logic BVINV_DIVIDEND = 1'b0;
    localparam logic BVINV_DIVISOR  = 1'b1;

    // Widths of 64 shift the one out entirely, so the subtraction still yields all ones.
    function automatic logic [63:0] all_ones(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/bvudiv_seq_core.sv
// WIDTH-cycle restoring unsigned divider; a zero divisor yields all ones (SMT-LIB udiv).
module bvudiv_seq_core
    import bvinv_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             fin,
    output logic [WIDTH-1:0] quot
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] src_rem, src_num, src_div;
    logic [WIDTH:0]   trial;
    logic             fits;

    // The go edge performs the first iteration so the result is ready after WIDTH edges.
    always_comb begin
        src_rem = go ? '0 : rem_q;
        src_num = go ? dividend : num_q;
        src_div = go ? divisor : div_q;
        trial   = {src_rem, src_num[WIDTH-1]};
        fits    = trial >= {1'b0, src_div};
    end

    assign fin  = (cnt_q == CW'(WIDTH));
    assign quot = zero_q ? ONES : num_q;

    always_comb begin
        rem_d  = rem_q;
        num_d  = num_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        zero_d = zero_q;
        if (go || (cnt_q != '0 && !fin)) begin
            rem_d = fits ? WIDTH'(trial - {1'b0, src_div}) : trial[WIDTH-1:0];
            num_d = {src_num[WIDTH-2:0], fits};
            cnt_d = cnt_q + CW'(1);
        end
        if (go) begin
            div_d  = divisor;
            zero_d = (divisor == '0);
            cnt_d  = CW'(1);
        end else if (fin) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            num_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            num_q  <= num_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: rtl/bvudiv_inv_solver.sv
// Inverse solver for unsigned udiv: finds x with x udiv s = t (mode 0) or s udiv x = t (mode 1).
module bvudiv_inv_solver
    import bvinv_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] t,
    output logic             ready,
    output logic             done,
    output logic             inv,
    output logic [WIDTH-1:0] x
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

    bvinv_state_e       state_q, state_d;
    logic [WIDTH-1:0]   s_q, s_d, t_q, t_d, q_q, q_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_x_q, res_x_d, x_q, x_d;
    logic               res_inv_q, res_inv_d, inv_q, inv_d, done_q, done_d;

    logic               core_go, core_fin;
    logic [WIDTH-1:0]   core_dividend, core_divisor, core_quot;
    logic               accept;

    // Busy through the done cycle; the one-cycle done pulse is issued from IDLE.
    assign ready  = (state_q == StIdle) && !done_q;
    assign accept = start && ready;
    assign done   = done_q;
    assign inv    = inv_q;
    assign x      = x_q;

    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        t_d           = t_q;
        q_d           = q_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        cnt_d         = cnt_q;
        res_x_d       = res_x_q;
        res_inv_d     = res_inv_q;
        x_d           = x_q;
        inv_d         = inv_q;
        done_d        = 1'b0;
        core_go       = 1'b0;
        core_dividend = s_q;
        core_divisor  = core_quot;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    s_d = s;
                    t_d = t;
                    if (mode == BVINV_DIVIDEND) begin
                        if (s == '0) begin
                            res_inv_d = (t == ONES);
                            res_x_d   = '0;
                            state_d   = StDone;
                        end else begin
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, s};
                            mplier_d = t;
                            cnt_d    = '0;
                            state_d  = StMul;
                        end
                    end else begin
                        if (t == '0) begin
                            res_inv_d = (s != ONES);
                            res_x_d   = (s != ONES) ? s + WIDTH'(1) : '0;
                            state_d   = StDone;
                        end else begin
                            core_go       = 1'b1;
                            core_dividend = s;
                            core_divisor  = t;
                            state_d       = StDivA;
                        end
                    end
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_inv_d = (acc_step[2*WIDTH-1:WIDTH] == '0);
                    res_x_d   = (acc_step[2*WIDTH-1:WIDTH] == '0) ? acc_step[WIDTH-1:0] : '0;
                    state_d   = StDone;
                end
            end
            StDivA: begin
                // Candidate q = s udiv t, immediately fed back as the verify divisor.
                if (core_fin) begin
                    q_d           = core_quot;
                    core_go       = 1'b1;
                    core_dividend = s_q;
                    core_divisor  = core_quot;
                    state_d       = StDivB;
                end
            end
            StDivB: begin
                if (core_fin) begin
                    res_inv_d = (core_quot == t_q);
                    res_x_d   = (core_quot == t_q) ? q_q : '0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                x_d     = res_x_q;
                inv_d   = res_inv_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            s_q       <= '0;
            t_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            res_x_q   <= '0;
            res_inv_q <= 1'b0;
            x_q       <= '0;
            inv_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            t_q       <= t_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            res_x_q   <= res_x_d;
            res_inv_q <= res_inv_d;
            x_q       <= x_d;
            inv_q     <= inv_d;
            done_q    <= done_d;
        end
    end

    bvudiv_seq_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (core_go),
        .dividend(core_dividend),
        .divisor (core_divisor),
        .fin     (core_fin),
        .quot    (core_quot)
    );

endmodule

// File: tb/tb_bvudiv_inv_solver.sv
// Scoreboard bench for bvudiv_inv_solver at WIDTH=4.
module tb_bvudiv_inv_solver;

    localparam int unsigned WIDTH = 4;

    typedef struct {
        logic [3:0] x;
        logic       inv;
        int         lat;
        int         acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [WIDTH-1:0] s = '0;
    logic [WIDTH-1:0] t = '0;
    logic             ready, done, inv;
    logic [WIDTH-1:0] x;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t hold;
    logic chk_hold = 1'b0;
    logic accepted;

    bvudiv_inv_solver #(
        .WIDTH(WIDTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .mode (mode),
        .s    (s),
        .t    (t),
        .ready(ready),
        .done (done),
        .inv  (inv),
        .x    (x)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int udiv(input int a, input int b);
        return (b == 0) ? 15 : a / b;
    endfunction

    function automatic exp_t model(input logic m, input logic [3:0] sv, input logic [3:0] tv);
        exp_t r;
        int   p, q, v;
        r.acc = 0;
        if (!m) begin
            if (sv == 0) begin
                r.inv = (tv == 4'd15);
                r.x   = 4'd0;
                r.lat = 1;
            end else begin
                p     = int'(sv) * int'(tv);
                r.inv = (p < 16);
                r.x   = r.inv ? p[3:0] : 4'd0;
                r.lat = 5;
            end
        end else begin
            if (tv == 0) begin
                r.inv = (sv != 4'd15);
                r.x   = r.inv ? sv + 4'd1 : 4'd0;
                r.lat = 1;
            end else begin
                q     = udiv(int'(sv), int'(tv));
                v     = udiv(int'(sv), q);
                r.inv = (v == int'(tv));
                r.x   = r.inv ? q[3:0] : 4'd0;
                r.lat = 9;
            end
        end
        return r;
    endfunction

    // Called with inputs set just after a negedge; decides acceptance before the next posedge.
    task automatic step();
        exp_t e;
        #1;
        accepted = start && ready;
        if (accepted) begin
            e     = model(mode, s, t);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic m, input logic [3:0] sv, input logic [3:0] tv);
        mode     = m;
        s        = sv;
        t        = tv;
        start    = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) step();
        start = 1'b0;
        check_eq("accept_timeout", {31'b0, accepted}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        check_eq("done_timeout", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk_hold = 1'b0;
        end else begin
            if (chk_hold) begin
                check_eq("ready_after_done", ready, 1'b1);
                check_eq("x_held", x, hold.x);
                check_eq("inv_held", inv, hold.inv);
                chk_hold = 1'b0;
            end
            if (done) begin
                check_eq("ready_in_done", ready, 1'b0);
                if (sb.size() == 0) begin
                    check_eq("spurious_done", done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check_eq("x", x, e.x);
                    check_eq("inv", inv, e.inv);
                    check_eq("latency", cyc - e.acc, e.lat);
                    hold     = e;
                    chk_hold = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_ready", ready, 1'b1);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_inv", inv, 1'b0);
        check_eq("rst_x", x, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases: overflow, s=0, t=0, q=0 verify and a failing verify.
        issue(1'b0, 4'd3, 4'd4);   wait_idle();
        issue(1'b0, 4'd5, 4'd4);   wait_idle();
        issue(1'b0, 4'd0, 4'd15);  wait_idle();
        issue(1'b0, 4'd0, 4'd3);   wait_idle();
        issue(1'b1, 4'd13, 4'd3);  wait_idle();
        issue(1'b1, 4'd7, 4'd4);   wait_idle();
        issue(1'b1, 4'd9, 4'd0);   wait_idle();
        issue(1'b1, 4'd15, 4'd0);  wait_idle();
        issue(1'b1, 4'd5, 4'd15);  wait_idle();

        // A start pulse while busy must be dropped.
        issue(1'b0, 4'd3, 4'd4);
        step();
        mode  = 1'b1;
        s     = 4'd9;
        t     = 4'd0;
        start = 1'b1;
        #1;
        check_eq("ready_busy", ready, 1'b0);
        step();
        start = 1'b0;
        wait_idle();
        repeat (10) step();

        // Start held high: back-to-back requests.
        mode  = 1'b1;
        s     = 4'd13;
        t     = 4'd3;
        start = 1'b1;
        repeat (30) step();
        start = 1'b0;
        wait_idle();
        mode  = 1'b0;
        s     = 4'd2;
        t     = 4'd7;
        start = 1'b1;
        repeat (16) step();
        start = 1'b0;
        wait_idle();

        // Reset in the middle of the verify division.
        issue(1'b1, 4'd13, 4'd3);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", ready, 1'b1);
        check_eq("midrst_x", x, 0);
        check_eq("midrst_done", done, 1'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (14) step();
        issue(1'b1, 4'd13, 4'd3);  wait_idle();

        for (int i = 0; i < 24; i++) begin
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
